aud_seq: RTL and testbench

Top-level transport sequencer for the audio recorder/player. Turns debounced key pulses (record, play, stop) into one-cycle start/pause/stop commands for the recorder and for AudDSP. It owns the SRAM ownership select and latches the end-of-recording address. Playback stops automatically when the DSP read address reaches that address, and recording stops automatically when SRAM is full.

---
 rtl/aud_seq.sv | 140 ++++++++++++++
 tb/tb_aud_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/aud_seq.sv
// aud_seq: record/play transport sequencer with registered one-cycle commands; define AUD_SEQ_LOOP_EN to loop playback at end of data
module aud_seq #(
  parameter int ADDR_W  = 20,
  parameter int HOLDOFF = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic              o_sram_sel,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [2:0]        o_state
);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_REC        = 3'd1;
  localparam logic [2:0] S_REC_PAUSE  = 3'd2;
  localparam logic [2:0] S_PLAY       = 3'd3;
  localparam logic [2:0] S_PLAY_PAUSE = 3'd4;
  localparam logic [2:0] S_RESTART    = 3'd5;
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
`ifdef AUD_SEQ_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              sram_sel_q, sram_sel_d;
  logic              rec_start_q, rec_start_d, rec_pause_q, rec_pause_d, rec_stop_q, rec_stop_d;
  logic              dsp_start_q, dsp_start_d, dsp_pause_q, dsp_pause_d, dsp_stop_q, dsp_stop_d;
  logic              k_stop, k_rec, k_play, full, done;
  always_comb begin
    k_stop      = i_key_stop;
    k_rec       = i_key_rec & ~i_key_stop;
    k_play      = i_key_play & ~i_key_rec & ~i_key_stop;
    full        = &i_rec_addr;
    done        = (hold_q == '0) && (i_play_addr >= end_addr_q);
    state_d     = state_q;
    end_addr_d  = end_addr_q;
    rec_start_d = 1'b0;
    rec_pause_d = 1'b0;
    rec_stop_d  = 1'b0;
    dsp_start_d = 1'b0;
    dsp_pause_d = 1'b0;
    dsp_stop_d  = 1'b0;
    hold_d      = (state_q == S_PLAY && hold_q != '0) ? hold_q - 1'b1 : hold_q;
    case (state_q)
      S_IDLE: begin
        if (k_rec) begin
          rec_start_d = 1'b1;
          state_d     = S_REC;
        end else if (k_play && end_addr_q != '0) begin
          dsp_start_d = 1'b1;
          state_d     = S_PLAY;
        end
      end
      S_REC, S_REC_PAUSE: begin
        if (k_stop || (state_q == S_REC && full)) begin
          rec_stop_d = 1'b1;
          end_addr_d = i_rec_addr;
          state_d    = S_IDLE;
        end else if (k_rec) begin
          rec_pause_d = state_q == S_REC;
          rec_start_d = state_q == S_REC_PAUSE;
          state_d     = (state_q == S_REC) ? S_REC_PAUSE : S_REC;
        end
      end
      S_PLAY: begin
        if (k_stop || done) begin
          dsp_stop_d = 1'b1;
          state_d    = (LOOP && !k_stop) ? S_RESTART : S_IDLE;
        end else if (k_play) begin
          dsp_pause_d = 1'b1;
          state_d     = S_PLAY_PAUSE;
        end
      end
      S_PLAY_PAUSE: begin
        if (k_stop) begin
          dsp_stop_d = 1'b1;
          state_d    = S_IDLE;
        end else if (k_play) begin
          dsp_start_d = 1'b1;
          state_d     = S_PLAY;
        end
      end
      S_RESTART: begin
        dsp_start_d = !k_stop;
        state_d     = k_stop ? S_IDLE : S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
    // every entry into PLAY (start, resume, restart) masks end detection afresh
    if (state_d == S_PLAY && state_q != S_PLAY) hold_d = HW'(HOLDOFF);
    sram_sel_d = (state_d == S_REC) || (state_d == S_REC_PAUSE);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      end_addr_q  <= '0;
      hold_q      <= '0;
      sram_sel_q  <= 1'b0;
      rec_start_q <= 1'b0;
      rec_pause_q <= 1'b0;
      rec_stop_q  <= 1'b0;
      dsp_start_q <= 1'b0;
      dsp_pause_q <= 1'b0;
      dsp_stop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      end_addr_q  <= end_addr_d;
      hold_q      <= hold_d;
      sram_sel_q  <= sram_sel_d;
      rec_start_q <= rec_start_d;
      rec_pause_q <= rec_pause_d;
      rec_stop_q  <= rec_stop_d;
      dsp_start_q <= dsp_start_d;
      dsp_pause_q <= dsp_pause_d;
      dsp_stop_q  <= dsp_stop_d;
    end
  end
  assign o_state     = state_q;
  assign o_end_addr  = end_addr_q;
  assign o_sram_sel  = sram_sel_q;
  assign o_rec_start = rec_start_q;
  assign o_rec_pause = rec_pause_q;
  assign o_rec_stop  = rec_stop_q;
  assign o_dsp_start = dsp_start_q;
  assign o_dsp_pause = dsp_pause_q;
  assign o_dsp_stop  = dsp_stop_q;
endmodule

// File: tb/tb_aud_seq.sv
// tb_aud_seq: directed stimulus checked every cycle against a behavioural transport model plus literal expectations
module tb_aud_seq;
  localparam int AW = 20;
  localparam int HO = 4;
`ifdef AUD_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic k_rec = 1'b0, k_play = 1'b0, k_stop = 1'b0;
  logic [AW-1:0] rec_addr = '0, play_addr = '0;
  logic o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop, o_sram_sel;
  logic [AW-1:0] o_end_addr;
  logic [2:0] o_state;
  aud_seq #(.ADDR_W(AW), .HOLDOFF(HO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_key_rec(k_rec), .i_key_play(k_play), .i_key_stop(k_stop),
    .i_rec_addr(rec_addr), .i_play_addr(play_addr),
    .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
    .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause), .o_dsp_stop(o_dsp_stop),
    .o_sram_sel(o_sram_sel), .o_end_addr(o_end_addr), .o_state(o_state)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int m_state = 0;
  int m_age = 0;
  logic [AW-1:0] m_end = '0;
  logic m_rs, m_rp, m_rst, m_ds, m_dp, m_dst, m_sel;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Transport rules: state 0 idle, 1 rec, 2 rec pause, 3 play, 4 play pause, 5 restart.
  task automatic model_step();
    int key;
    bit ended;
    {m_rs, m_rp, m_rst, m_ds, m_dp, m_dst} = '0;
    if (!rst_n) begin
      m_state = 0;
      m_end = '0;
      m_sel = 1'b0;
      return;
    end
    key = k_stop ? 3 : k_rec ? 2 : k_play ? 1 : 0;
    ended = (m_age >= HO) && (play_addr >= m_end);
    case (m_state)
      0: if (key == 2) begin m_rs = 1; m_state = 1; end
         else if (key == 1 && m_end != 0) begin m_ds = 1; m_state = 3; m_age = 0; end
      1: if (key == 3 || rec_addr == '1) begin m_rst = 1; m_end = rec_addr; m_state = 0; end
         else if (key == 2) begin m_rp = 1; m_state = 2; end
      2: if (key == 3) begin m_rst = 1; m_end = rec_addr; m_state = 0; end
         else if (key == 2) begin m_rs = 1; m_state = 1; end
      3: if (key == 3) begin m_dst = 1; m_state = 0; end
         else if (ended) begin m_dst = 1; m_state = LOOP ? 5 : 0; end
         else if (key == 1) begin m_dp = 1; m_state = 4; end
         else m_age++;
      4: if (key == 3) begin m_dst = 1; m_state = 0; end
         else if (key == 1) begin m_ds = 1; m_state = 3; m_age = 0; end
      5: if (key == 3) m_state = 0;
         else begin m_ds = 1; m_state = 3; m_age = 0; end
      default: m_state = 0;
    endcase
    m_sel = (m_state == 1 || m_state == 2);
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("rec_start", o_rec_start, m_rs);
    chk("rec_pause", o_rec_pause, m_rp);
    chk("rec_stop", o_rec_stop, m_rst);
    chk("dsp_start", o_dsp_start, m_ds);
    chk("dsp_pause", o_dsp_pause, m_dp);
    chk("dsp_stop", o_dsp_stop, m_dst);
    chk("sram_sel", o_sram_sel, m_sel);
    chk("end_addr", o_end_addr, m_end);
    chk("state", o_state, m_state);
    k_rec = 1'b0;
    k_play = 1'b0;
    k_stop = 1'b0;
  endtask
  initial begin
    int n, stops;
    step();
    step();
    chk("lit_rst_state", o_state, 0);
    chk("lit_rst_end", o_end_addr, 0);
    rst_n = 1'b1;
    k_play = 1'b1; step();
    chk("lit_play_empty_start", o_dsp_start, 0);
    chk("lit_play_empty_state", o_state, 0);
    k_rec = 1'b1; step();
    chk("lit_rec_start", o_rec_start, 1);
    chk("lit_rec_sel", o_sram_sel, 1);
    rec_addr = 20'h00064;
    for (int i = 0; i < 100; i++) step();
    k_stop = 1'b1; step();
    chk("lit_rec_stop", o_rec_stop, 1);
    chk("lit_end_64", o_end_addr, 20'h00064);
    chk("lit_sel_after", o_sram_sel, 0);
    step();
    chk("lit_rec_stop_one", o_rec_stop, 0);
    play_addr = '0;
    k_play = 1'b1; step();
    chk("lit_ramp_start", o_dsp_start, 1);
    stops = 0;
    for (int a = 1; a <= 100; a++) begin
      play_addr = AW'(a);
      step();
      if (a < 100) stops += int'(o_dsp_stop);
    end
    chk("lit_no_early_stop", stops, 0);
    chk("lit_end_stop", o_dsp_stop, 1);
    chk("lit_end_state", o_state, LOOP ? 5 : 0);
    step();
    k_stop = 1'b1; step();
    play_addr = '0;
    k_play = 1'b1; step();
    k_play = 1'b1; step();
    chk("lit_pause", o_dsp_pause, 1);
    chk("lit_pause_state", o_state, 4);
    k_play = 1'b1; step();
    chk("lit_resume", o_dsp_start, 1);
    chk("lit_resume_state", o_state, 3);
    k_stop = 1'b1; step();
    k_rec = 1'b1; step();
    rec_addr = 20'h00123;
    step();
    k_rec = 1'b1; k_stop = 1'b1; k_play = 1'b1; step();
    chk("lit_coinc_stop", o_rec_stop, 1);
    chk("lit_coinc_pause", o_rec_pause, 0);
    chk("lit_coinc_state", o_state, 0);
    chk("lit_coinc_end", o_end_addr, 20'h00123);
    k_rec = 1'b1; step();
    k_rec = 1'b1; step();
    rec_addr = '1;
    step(); step();
    chk("lit_pause_nofull", o_state, 2);
    k_rec = 1'b1; step();
    step();
    chk("lit_full_stop", o_rec_stop, 1);
    chk("lit_full_end", o_end_addr, 20'hFFFFF);
    play_addr = '1;
    k_play = 1'b1; step();
    n = 0;
    while (!o_dsp_stop && n < 50) begin step(); n++; end
    chk("lit_holdoff_lat", n, HO + 1);
    k_stop = 1'b1; step();
    play_addr = '0;
    k_play = 1'b1; step();
    step(); step();
    rst_n = 1'b0; step();
    chk("lit_rst_play_state", o_state, 0);
    chk("lit_rst_play_stop", o_dsp_stop, 0);
    chk("lit_rst_play_end", o_end_addr, 0);
    rst_n = 1'b1; step();
    chk("lit_rst_after_stop", o_dsp_stop, 0);
    k_play = 1'b1; step();
    chk("lit_play_after_rst", o_dsp_start, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
